// File: rtl/mul_norm.sv
// Normalise, round-to-nearest-even and saturate a raw mantissa product.
// Two-stage valid/ready pipeline: S1 plans the shift, S2 shifts, rounds and packs.
module mul_norm #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIGN_W-1:0]        in_sign,
    input  logic signed [EXPO_W+1:0] in_expo,
    input  logic [2*MANT_W+1:0]      in_prod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIGN_W-1:0]        out_sign,
    output logic [EXPO_W-1:0]        out_expo,
    output logic [MANT_W-1:0]        out_mant,
    output logic                     out_inexact,
    output logic                     out_ovf
);

    localparam int PROD_W = 2*MANT_W + 2;
    localparam int ET_W   = EXPO_W + 3;
    localparam int SH_W   = $clog2(PROD_W + 1);
    localparam logic signed [ET_W-1:0] EXPO_MAX = ET_W'((1 << EXPO_W) - 1);
    localparam logic signed [ET_W-1:0] PROD_LIM = ET_W'(PROD_W);

    typedef struct packed {
        logic [EXPO_W-1:0] expo;
        logic [MANT_W-1:0] mant;
        logic              inexact;
        logic              ovf;
    } res_t;

    function automatic logic [SH_W-1:0] count_lz(input logic [PROD_W-1:0] v);
        logic [SH_W-1:0] n;
        logic            found;
        n     = SH_W'(PROD_W);
        found = 1'b0;
        for (int i = PROD_W-1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = SH_W'(PROD_W-1-i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Result MSB is the carry-out into the exponent; low bits are the new fraction.
    function automatic logic [MANT_W:0] round_rne(input logic [MANT_W-1:0] frac,
                                                  input logic guard,
                                                  input logic sticky);
        logic inc;
        inc = guard & (sticky | frac[0]);
        return {1'b0, frac} + {{MANT_W{1'b0}}, inc};
    endfunction

    function automatic res_t saturate(input logic signed [ET_W-1:0] expo,
                                      input logic [MANT_W-1:0] mant,
                                      input logic inexact);
        res_t r;
        if (expo >= EXPO_MAX) begin
            r.expo    = '1;
            r.mant    = '0;
            r.inexact = 1'b1;
            r.ovf     = 1'b1;
        end else begin
            r.expo    = expo[EXPO_W-1:0];
            r.mant    = mant;
            r.inexact = inexact;
            r.ovf     = 1'b0;
        end
        return r;
    endfunction

    logic                    vld_p1, vld_p2, s2_en;
    logic [SIGN_W-1:0]       sign_p1, sign_p2;
    logic [PROD_W-1:0]       prod_p1;
    logic signed [ET_W-1:0]  e_tgt_p1;
    logic [SH_W-1:0]         lz_p1, shamt_p1;
    logic                    left_p1;
    logic [EXPO_W-1:0]       expo_p2;
    logic [MANT_W-1:0]       mant_p2;
    logic                    inexact_p2, ovf_p2;

    assign s2_en    = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_en;

    // ---- Stage 1: leading zeros, target exponent, shift direction/amount ----
    logic [SH_W-1:0]        lz_c, shamt_c;
    logic signed [ET_W-1:0] e_tgt_c, lz_s, lim_c, rsh_c;
    logic                   left_c;

    always_comb begin
        lz_c    = count_lz(in_prod);
        e_tgt_c = ET_W'(in_expo) + ET_W'(1);
        lz_s    = $signed(ET_W'(lz_c));
        lim_c   = e_tgt_c - ET_W'(1);
        rsh_c   = ET_W'(1) - e_tgt_c;
        left_c  = (e_tgt_c > ET_W'(0));
        shamt_c = '0;
        if (left_c) begin
            // Normalise, but never below exponent 1; the rest stays subnormal.
            shamt_c = (lim_c < lz_s) ? lim_c[SH_W-1:0] : lz_c;
        end else if (rsh_c > PROD_LIM) begin
            shamt_c = SH_W'(PROD_W);
        end else begin
            shamt_c = rsh_c[SH_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            sign_p1  <= '0;
            prod_p1  <= '0;
            e_tgt_p1 <= '0;
            lz_p1    <= '0;
            left_p1  <= 1'b0;
            shamt_p1 <= '0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sign_p1  <= in_sign;
                prod_p1  <= in_prod;
                e_tgt_p1 <= e_tgt_c;
                lz_p1    <= lz_c;
                left_p1  <= left_c;
                shamt_p1 <= shamt_c;
            end
        end
    end

    // ---- Stage 2: shift, extract guard/sticky, round, saturate ----
    logic [2*PROD_W-1:0]    wide_c;
    logic [PROD_W-1:0]      shifted_c;
    logic [MANT_W-1:0]      frac_c;
    logic                   lost_c, guard_c, sticky_c;
    logic signed [ET_W-1:0] exp_pre_c, exp_rnd_c;
    logic [MANT_W:0]        rnd_c;
    res_t                   res_c;

    always_comb begin
        // Low half catches bits pushed out by a right shift.
        wide_c    = {prod_p1, {PROD_W{1'b0}}};
        wide_c    = left_p1 ? (wide_c << shamt_p1) : (wide_c >> shamt_p1);
        shifted_c = wide_c[2*PROD_W-1 -: PROD_W];
        lost_c    = |wide_c[PROD_W-1:0];
        frac_c    = shifted_c[PROD_W-2 -: MANT_W];
        guard_c   = shifted_c[PROD_W-2-MANT_W];
        sticky_c  = (|shifted_c[PROD_W-3-MANT_W:0]) | lost_c;
        exp_pre_c = shifted_c[PROD_W-1] ? (e_tgt_p1 - $signed(ET_W'(shamt_p1))) : '0;
        rnd_c     = round_rne(frac_c, guard_c, sticky_c);
        exp_rnd_c = exp_pre_c + $signed(ET_W'(rnd_c[MANT_W]));
        res_c     = saturate(exp_rnd_c, rnd_c[MANT_W-1:0], guard_c | sticky_c);
        if (lz_p1 == SH_W'(PROD_W)) begin
            res_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            sign_p2    <= '0;
            expo_p2    <= '0;
            mant_p2    <= '0;
            inexact_p2 <= 1'b0;
            ovf_p2     <= 1'b0;
        end else if (s2_en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sign_p2    <= sign_p1;
                expo_p2    <= res_c.expo;
                mant_p2    <= res_c.mant;
                inexact_p2 <= res_c.inexact;
                ovf_p2     <= res_c.ovf;
            end
        end
    end

    assign out_valid   = vld_p2;
    assign out_sign    = sign_p2;
    assign out_expo    = expo_p2;
    assign out_mant    = mant_p2;
    assign out_inexact = inexact_p2;
    assign out_ovf     = ovf_p2;

endmodule

// File: tb/tb_mul_norm.sv
// Bench for mul_norm: value-based rounding model, scoreboard, directed and random traffic.
module tb_mul_norm;

    localparam int MW = 23;
    localparam int EW = 8;
    localparam int PW = 48;

    logic              clk, rst_n;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [0:0]        in_sign, out_sign;
    logic signed [9:0] in_expo;
    logic [47:0]       in_prod;
    logic [7:0]        out_expo;
    logic [22:0]       out_mant;
    logic              out_inexact, out_ovf;

    mul_norm #(.SIGN_W(1), .EXPO_W(EW), .MANT_W(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_expo(in_expo), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_expo(out_expo), .out_mant(out_mant),
        .out_inexact(out_inexact), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic        inx;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    int   del_cnt = 0;
    bit   lat_mode = 0;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value model: quantise prod * 2^(e_tgt-47) onto the float grid with RNE.
    function automatic exp_t ref_model(input logic s, input logic signed [9:0] expo,
                                       input logic [47:0] prod);
        exp_t r;
        int et, msb, lz, ee, ebase, k;
        bit [127:0] m, qq, rem, half;
        bit rem_nz;
        r.s = s; r.e = 0; r.m = 0; r.inx = 0; r.ovf = 0; r.acc = 0; r.lat = 0;
        if (prod == 0) return r;
        et  = int'(expo) + 1;
        msb = -1;
        for (int i = 0; i < PW; i++) if (prod[i]) msb = i;
        lz    = PW - 1 - msb;
        ee    = et - lz;
        if (ee < 1) ee = 0;
        ebase = (ee < 1) ? 1 : ee;
        k     = et - (PW - 1) - ebase + MW;
        rem_nz = 0;
        if (k >= 0) begin
            m = 128'(prod) << k;
        end else if (-k > 100) begin
            m = 0;
            rem_nz = 1;
        end else begin
            qq   = 128'(prod) >> (-k);
            rem  = 128'(prod) - (qq << (-k));
            half = 128'(1) << (-k - 1);
            rem_nz = (rem != 0);
            if (rem > half || (rem == half && qq[0])) qq = qq + 1;
            m = qq;
        end
        if (m >= (128'(1) << (MW + 1))) begin
            ee = ee + 1;
            m  = m >> 1;
        end
        if (ee == 0 && m >= (128'(1) << MW)) ee = 1;
        if (ee >= (1 << EW) - 1) begin
            r.e = 8'hFF; r.m = 0; r.inx = 1; r.ovf = 1;
        end else begin
            r.e = ee[7:0]; r.m = m[22:0]; r.inx = rem_nz;
        end
        return r;
    endfunction

    task automatic pin(input string name, input logic signed [9:0] e, input logic [47:0] p,
                       input logic [7:0] xe, input logic [22:0] xm, input logic xi, input logic xo);
        exp_t r;
        r = ref_model(1'b0, e, p);
        chk(name, 64'({r.e, r.m, r.inx, r.ovf}), 64'({xe, xm, xi, xo}));
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    exp_t        me;
    bit          held_v = 0;
    logic [34:0] held_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held_v = 0;
        end else begin
            if (held_v)
                chk("hold_stable", 64'({out_valid, out_sign, out_expo, out_mant, out_inexact, out_ovf}),
                    64'(held_w));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got expo %0h mant %0h, required none", out_expo, out_mant);
                end else begin
                    me = q.pop_front();
                    chk("beat", 64'({out_sign, out_expo, out_mant, out_inexact, out_ovf}),
                        64'({me.s, me.e, me.m, me.inx, me.ovf}));
                    if (me.lat && lat_mode) chk("latency", 64'(cyc - me.acc), 64'(2));
                    del_cnt++;
                end
            end
            held_v = out_valid && !out_ready;
            held_w = {out_valid, out_sign, out_expo, out_mant, out_inexact, out_ovf};
            if (in_valid && in_ready) begin
                me     = ref_model(in_sign[0], in_expo, in_prod);
                me.acc = cyc;
                me.lat = lat_mode;
                q.push_back(me);
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic s, input logic signed [9:0] e, input logic [47:0] p);
        int t;
        in_valid = 1'b1; in_sign = s; in_expo = e; in_prod = p;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk); #1;
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic rand_beat();
        logic [63:0]       r64;
        logic [47:0]       p;
        int                v;
        logic signed [9:0] e;
        r64 = {$urandom(), $urandom()};
        p   = r64[47:0];
        if ($urandom_range(0, 1) == 1) p = p >> $urandom_range(0, 48);
        if ($urandom_range(0, 7) == 0) p = {1'b1, p[46:24], 1'b1, 23'd0};
        case ($urandom_range(0, 4))
            0:       v = 100 + int'($urandom_range(0, 60));
            1:       v = 240 + int'($urandom_range(0, 25));
            2:       v = int'($urandom_range(0, 60)) - 30;
            3:       v = int'($urandom_range(0, 1023)) - 512;
            default: v = int'($urandom_range(0, 60));
        endcase
        e = 10'(v);
        send(1'($urandom_range(0, 1)), e, p);
    endtask

    bit prod_done;
    int a0, d0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sign = '0; in_expo = '0; in_prod = '0;
        out_ready = 1'b1;

        pin("pin_norm",      10'sd127, 48'h800000000000, 8'd128, 23'h0, 1'b0, 1'b0);
        pin("pin_shift1",    10'sd127, 48'h400000000000, 8'd127, 23'h0, 1'b0, 1'b0);
        pin("pin_tie_even",  10'sd127, 48'h800000800000, 8'd128, 23'h0, 1'b1, 1'b0);
        pin("pin_tie_odd",   10'sd127, 48'h800001800000, 8'd128, 23'h2, 1'b1, 1'b0);
        pin("pin_subn_left", 10'sd3,   48'h010000000000, 8'd0,   23'h080000, 1'b0, 1'b0);
        pin("pin_subn_right", -10'sd2, 48'h800000000000, 8'd0,   23'h200000, 1'b0, 1'b0);
        pin("pin_ovf",       10'sd254, 48'h800000000000, 8'hFF,  23'h0, 1'b1, 1'b1);
        pin("pin_zero",      10'sd127, 48'h0,            8'd0,   23'h0, 1'b0, 1'b0);
        pin("pin_promote",   -10'sd1,  48'hFFFFFFFFFFFF, 8'd1,   23'h0, 1'b1, 1'b0);
        pin("pin_rnd_ovf",   10'sd253, 48'hFFFFFFFFFFFF, 8'hFF,  23'h0, 1'b1, 1'b1);

        repeat (2) @(posedge clk); #1;
        chk("reset_outputs", 64'({out_valid, out_sign, out_expo, out_mant, out_inexact, out_ovf}), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Directed corner beats, back to back with the sink always ready.
        lat_mode = 1;
        send(1'b0, 10'sd127, 48'h800000000000);
        send(1'b1, 10'sd127, 48'h400000000000);
        send(1'b0, 10'sd127, 48'h800000800000);
        send(1'b0, 10'sd127, 48'h800001800000);
        send(1'b0, 10'sd3,   48'h010000000000);
        send(1'b1, -10'sd2,  48'h800000000000);
        send(1'b0, 10'sd254, 48'h800000000000);
        send(1'b0, 10'sd127, 48'h0);
        send(1'b0, -10'sd1,  48'hFFFFFFFFFFFF);
        send(1'b1, 10'sd253, 48'hFFFFFFFFFFFF);
        drain();

        // Backpressure: sink stalls for three cycles under a 4-beat burst.
        lat_mode = 0;
        out_ready = 1'b0;
        a0 = acc_cnt; d0 = del_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send(1'b0, 10'(100 + i), {1'b1, 47'(i * 12345)});
                in_valid = 1'b0;
            end
            begin
                @(posedge clk); @(posedge clk); @(negedge clk);
                chk("bp_accepted", 64'(acc_cnt - a0), 64'(2));
                chk("bp_in_ready_low", 64'(in_ready), 64'(0));
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_delivered", 64'(del_cnt - d0), 64'(4));

        // Random traffic with random sink stalls.
        prod_done = 0;
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    rand_beat();
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
                    end
                end
                in_valid = 1'b0;
                prod_done = 1;
            end
            begin
                while (!prod_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a stream.
        lat_mode = 1;
        send(1'b0, 10'sd127, 48'h800000000000);
        send(1'b0, 10'sd127, 48'h800000000000);
        send(1'b0, 10'sd127, 48'h800000000000);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 64'({out_valid, out_sign, out_expo, out_mant, out_inexact, out_ovf}), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            chk("no_stale_beat", 64'(out_valid), 64'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        d0 = del_cnt;
        send(1'b1, 10'sd127, 48'h400000000000);
        drain();
        chk("post_reset_delivered", 64'(del_cnt - d0), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
